// File: rtl/ex_bus_responder.sv
// ex_bus_responder
// Target-side endpoint of the external host bus in front of the four SPM
// banks. Host commands are queued in an in-order FIFO. Each command is issued
// to its bank only in a cycle where the CGRA side is not using that bank.
// Read data returns to the host two cycles after issue, with a one-cycle strobe.
//
// Ports:
//   clk, rst     - single clock, synchronous active-low reset
//   ex_bus       - host command {wen, ren, addr[A_W-1:0], data[D_W-1:0]}
//   ex_ready     - command FIFO not full (0 while reset is asserted)
//   ex_rdata     - read return data, qualified by ex_rvalid
//   ex_rvalid    - one-cycle read return strobe
//   spm_busy     - per-bank CGRA ownership; a busy bank is never driven
//   spm_en       - one-hot bank enable for the issuing command
//   spm_we       - write enable, qualified by spm_en
//   spm_addr     - word index within the bank
//   spm_wdata    - write data
//   spm_rdata    - bank read data, bank b at [b*D_W +: D_W], valid the cycle after enable
//   err_flags    - sticky: [0] command dropped on full FIFO, [1] wen and ren both high
//   cmd_cnt      - accepted command count, saturating at 16'hFFFF
module ex_bus_responder #(
    parameter int A_W   = 10,
    parameter int D_W   = 32,
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [2+A_W+D_W-1:0] ex_bus,
    output logic                 ex_ready,
    output logic [D_W-1:0]       ex_rdata,
    output logic                 ex_rvalid,
    input  logic [3:0]           spm_busy,
    output logic [3:0]           spm_en,
    output logic                 spm_we,
    output logic [A_W-3:0]       spm_addr,
    output logic [D_W-1:0]       spm_wdata,
    input  logic [4*D_W-1:0]     spm_rdata,
    output logic [1:0]           err_flags,
    output logic [15:0]          cmd_cnt
);

    localparam int PW  = $clog2(DEPTH) + 1;
    localparam int E_W = 1 + A_W + D_W;
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    // Host command fields
    logic           bus_wen;
    logic           bus_ren;
    logic [A_W-1:0] bus_addr;
    logic [D_W-1:0] bus_data;
    logic           present;
    logic           push;

    assign bus_wen  = ex_bus[2+A_W+D_W-1];
    assign bus_ren  = ex_bus[A_W+D_W];
    assign bus_addr = ex_bus[D_W +: A_W];
    assign bus_data = ex_bus[D_W-1:0];
    assign present  = bus_wen | bus_ren;

    // Command FIFO: extra pointer MSB distinguishes full from empty
    logic [E_W-1:0] fifo_mem [DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic           empty;
    logic           full;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) &&
                   (wr_ptr[PW-2:0] == rd_ptr[PW-2:0]);

    // ex_ready depends only on registered pointers, so a same-cycle pop
    // never admits an extra command into a full FIFO.
    assign ex_ready = rst && !full;
    assign push     = present && ex_ready;

    // Head entry decode
    logic [E_W-1:0] head;
    logic           head_we;
    logic [A_W-1:0] head_addr;
    logic [1:0]     head_bank;
    logic [D_W-1:0] head_data;
    logic           issue;

    assign head      = fifo_mem[rd_ptr[PW-2:0]];
    assign head_we   = head[E_W-1];
    assign head_addr = head[D_W +: A_W];
    assign head_bank = head_addr[A_W-1:A_W-2];
    assign head_data = head[D_W-1:0];

    // Strictly in-order: a busy head bank blocks all later entries
    assign issue = rst && !empty && !spm_busy[head_bank];

    always_comb begin
        spm_en = '0;
        spm_we = 1'b0;
        if (issue) begin
            spm_en[head_bank] = 1'b1;
            spm_we            = head_we;
        end
    end

    assign spm_addr  = head_addr[A_W-3:0];
    assign spm_wdata = head_data;

    // FIFO storage needs no reset; pointers define validity
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr[PW-2:0]] <= {bus_wen, bus_addr, bus_data};
        end
    end

    // Read return pipeline state
    logic       rd_pend;
    logic [1:0] rd_bank;

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            rd_pend   <= 1'b0;
            rd_bank   <= '0;
            ex_rdata  <= '0;
            ex_rvalid <= 1'b0;
            err_flags <= '0;
            cmd_cnt   <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
                if (cmd_cnt != 16'hFFFF) begin
                    cmd_cnt <= cmd_cnt + 16'd1;
                end
                if (bus_wen && bus_ren) begin
                    err_flags[1] <= 1'b1;
                end
            end else if (present) begin
                err_flags[0] <= 1'b1;
            end

            if (issue) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end

            // Bank read data lands one cycle after the enable; capture it
            // then and strobe ex_rvalid the cycle after.
            rd_pend   <= issue && !head_we;
            rd_bank   <= head_bank;
            ex_rvalid <= rd_pend;
            if (rd_pend) begin
                ex_rdata <= spm_rdata[rd_bank*D_W +: D_W];
            end
        end
    end

endmodule
